mux_out_checker: RTL

Scoreboard stage that sits directly downstream of the 2:1 selector block (`a`, `b`, `sel` -> `out`). It receives the same stimulus that drives the selector, plus the selector's output, and computes the expected result `sel ? b : a`. It compares that result against `out` over a programmed number of vectors and reports vector count, error count, first-failing index and a pass/fail verdict. It replaces ad-hoc `$display` inspection with a synthesizable, self-contained checker usable in benches and on-chip.

---
 rtl/mux_chk_pkg.sv | 17 +
 rtl/chk_delay_line.sv | 54 +++++
 rtl/mux_out_checker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mux_chk_pkg.sv
// Shared definitions for the 2:1 selector output checker: FSM encodings,
// latency limit and the reference selector function.
package mux_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MAX_LATENCY = 3;

  function automatic logic sel_expect(input logic a, input logic b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-depth {valid, data} delay line with synchronous flush; depth 0 is a
// pure wire-through so the compare sees the pushed entry in the same cycle.
module chk_delay_line
  import mux_chk_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  if (DEPTH < 0 || DEPTH > MAX_LATENCY) begin : g_bad_depth
    $error("chk_delay_line: DEPTH out of range");
  end

  if (DEPTH == 0) begin : g_wire
    logic unused_s;
    assign unused_s  = clk ^ rst ^ flush;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld_r;
    logic [W-1:0]     dat_r [DEPTH];

    // Shift stages; flush only needs to kill the valid bits
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
          dat_r[i] <= {W{1'b0}};
        end
      end else if (flush) begin
        vld_r <= {DEPTH{1'b0}};
      end else begin
        vld_r[0] <= in_valid;
        dat_r[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld_r[i] <= vld_r[i-1];
          dat_r[i] <= dat_r[i-1];
        end
      end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = dat_r[DEPTH-1];
  end

endmodule

// File: rtl/mux_out_checker.sv
// Scoreboard for a 2:1 selector: recomputes sel ? b : a, aligns it to the
// selector output and counts vectors, mismatches and the first failing index.
module mux_out_checker
  import mux_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 5,
  parameter int CNT_W       = 8,
  parameter int LATENCY     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             sel,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  if (LATENCY < 0 || LATENCY > MAX_LATENCY || NUM_VECTORS <= 0 ||
      NUM_VECTORS > (2 ** CNT_W) - 1) begin : g_bad_params
    $error("mux_out_checker: illegal LATENCY or NUM_VECTORS");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] NV       = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] NV_LAST  = CNT_W'(NUM_VECTORS - 1);

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] acc_cnt_r, vec_cnt_r, err_cnt_r, first_err_idx_r;
  logic             first_err_valid_r;

  logic start_s, accept_s, exp_s, dl_valid_s, dl_exp_s;
  logic cmp_s, mismatch_s, final_s, flush_s;

  // start is only honoured outside RUN; excess vectors are dropped by acc_cnt
  assign start_s    = start && (state_r != ST_RUN);
  assign accept_s   = (state_r == ST_RUN) && in_valid && (acc_cnt_r < NV);
  assign exp_s      = sel_expect(a, b, sel);
  assign cmp_s      = (state_r == ST_RUN) && dl_valid_s;
  assign mismatch_s = cmp_s && (dl_exp_s != out);
  assign final_s    = cmp_s && (vec_cnt_r == NV_LAST);
  assign flush_s    = start_s || final_s;

  chk_delay_line #(
    .DEPTH (LATENCY),
    .W     (1)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_s),
    .in_valid  (accept_s),
    .in_data   (exp_s),
    .out_valid (dl_valid_s),
    .out_data  (dl_exp_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_RUN;
        else       next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (final_s) next_state_s = ST_DONE;
        else         next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) next_state_s = ST_RUN;
        else       next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Accept counter bounds the number of vectors pushed per run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_r <= CNT_ZERO;
    end else if (start_s) begin
      acc_cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      acc_cnt_r <= acc_cnt_r + CNT_ONE;
    end
  end

  // Result counters and first-error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt_r         <= CNT_ZERO;
      err_cnt_r         <= CNT_ZERO;
      first_err_idx_r   <= CNT_ZERO;
      first_err_valid_r <= 1'b0;
    end else if (start_s) begin
      vec_cnt_r         <= CNT_ZERO;
      err_cnt_r         <= CNT_ZERO;
      first_err_idx_r   <= CNT_ZERO;
      first_err_valid_r <= 1'b0;
    end else if (cmp_s) begin
      vec_cnt_r <= vec_cnt_r + CNT_ONE;
      if (mismatch_s) begin
        if (err_cnt_r != CNT_ONES) begin
          err_cnt_r <= err_cnt_r + CNT_ONE;
        end
        if (!first_err_valid_r) begin
          first_err_idx_r   <= vec_cnt_r;
          first_err_valid_r <= 1'b1;
        end
      end
    end
  end

  assign busy            = (state_r == ST_RUN);
  assign done            = (state_r == ST_DONE);
  assign pass            = (state_r == ST_DONE) && (err_cnt_r == CNT_ZERO);
  assign vec_cnt         = vec_cnt_r;
  assign err_cnt         = err_cnt_r;
  assign first_err_idx   = first_err_idx_r;
  assign first_err_valid = first_err_valid_r;

endmodule
